// File: rtl/price_table.sv
`default_nettype none
// ============================================================================
// Module   : price_table
// Brief    : Programmable product-price store with registered lookups,
//            service-mode writes and a sequential default-load engine.
// Revision : 1.0 - initial release
// ============================================================================
module price_table #(
    parameter int N_PRODUCTS = 4,
    parameter int PRICE_W    = 8,
    parameter int PRICE_STEP = 5,
    localparam int ADDR_W    = (N_PRODUCTS > 2) ? $clog2(N_PRODUCTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic [PRICE_W-1:0] rd_price,
    output logic               rd_err,
    input  logic               svc_en,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PRICE_W-1:0] wr_data,
    output logic               wr_ack,
    output logic               wr_err,
    input  logic               restore,
    output logic               busy
);

    localparam logic [ADDR_W:0]    c_n    = N_PRODUCTS[ADDR_W:0];
    localparam logic [ADDR_W-1:0]  c_last = ADDR_W'(N_PRODUCTS - 1);
    localparam logic [PRICE_W-1:0] c_step = PRICE_STEP[PRICE_W-1:0];

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_RESTORE = 2'd2
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic [PRICE_W-1:0] r_def;
    logic [PRICE_W-1:0] r_mem [N_PRODUCTS];

    logic w_idle;
    logic w_rd_err;
    logic w_wr_inrange;
    logic w_restore;
    logic w_wr_accept;

    assign w_idle       = (r_state == S_IDLE);
    assign w_rd_err     = ({1'b0, rd_addr} >= c_n) || !w_idle;
    assign w_wr_inrange = ({1'b0, wr_addr} < c_n);
    assign w_restore    = w_idle && restore && svc_en;
    // A restore in the same cycle takes priority and turns the write into a reject.
    assign w_wr_accept  = wr_en && w_idle && svc_en && w_wr_inrange
                          && (wr_data != '0) && !w_restore;

    // Default value for entry idx is carried incrementally in r_def, so the
    // natural PRICE_W-bit wrap gives the truncated PRICE_STEP*(idx+1).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_idle) begin
                r_mem[r_idx] <= r_def;
            end else if (w_wr_accept) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_idx    <= '0;
            r_def    <= c_step;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_price <= '0;
            rd_err   <= 1'b0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_err   <= rd_req && w_rd_err;
            rd_price <= (rd_req && !w_rd_err) ? r_mem[rd_addr] : '0;
            wr_ack   <= w_wr_accept;
            wr_err   <= wr_en && !w_wr_accept;

            case (r_state)
                S_INIT, S_RESTORE: begin
                    r_def <= r_def + c_step;
                    if (r_idx == c_last) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_restore) begin
                        r_state <= S_RESTORE;
                        r_idx   <= '0;
                        r_def   <= c_step;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_idx   <= '0;
                    r_def   <= c_step;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
